// File: rtl/daq_frame_ctrl_if.sv
// daq_frame_ctrl_if: ring FIFO write port between the capture front-end and the FIFO.
// wr_en is a one-cycle strobe that carries one word on wr_data; the front-end
// only raises it in a cycle after seeing fifo_full low in its decision cycle,
// and a word that meets fifo_full high is dropped rather than held.
interface daq_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              fifo_full;

    modport master (output wr_en, output wr_data, input fifo_full);
    modport slave  (input wr_en, input wr_data, output fifo_full);
endinterface

// File: rtl/daq_frame_ctrl.sv
// daq_frame_ctrl: image-sensor capture front-end. Synchronises the sensor pixel
// bus and strobes into sys_clk, tracks frame/row state, decimates lines, counts
// pixels/lines/frames, writes the ring FIFO and raises a stretched interrupt per
// completed package.
// Optional build macro FRAME_HEADER_EN: writes a frame_cnt header word at every
// frame start, with a 1-entry skid register for a pixel that collides with it.
module daq_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter int PKG_SIZE  = 300,
    parameter int LINE_SKIP = 0,
    parameter int INTR_LEN  = 4,
    parameter int CNT_W     = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [DATA_W-1:0]   pix_data,
    input  logic                pix_clk,
    input  logic                frame_vaild,
    input  logic                line_vaild,
    daq_frame_ctrl_if.master    fifo_if,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    pix_cnt,
    output logic [CNT_W-1:0]    line_cnt,
    output logic [7:0]          frame_cnt,
    output logic                package_ready,
    output logic                intr_out,
    output logic                overflow
);
    localparam int PKG_W  = (PKG_SIZE > 1) ? $clog2(PKG_SIZE) : 1;
    localparam int INTR_W = $clog2(INTR_LEN + 1);
    localparam int SKIP_W = (LINE_SKIP > 0) ? $clog2(LINE_SKIP + 1) : 1;

    typedef enum logic [2:0] {
        ST_FOT = 3'b001,
        ST_WR  = 3'b010,
        ST_ROT = 3'b100
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          pclk_s, fv_s, lv_s;
    logic [DATA_W-1:0]   pd_s1, pd_s2, pd_smp;
    logic                pclk_d, smp, fv, lv;
    logic                line_keep, frame_wrote;
    logic [SKIP_W-1:0]   skip_cnt;
    logic [PKG_W-1:0]    pkg_cnt;
    logic [INTR_W-1:0]   intr_cnt;
    logic                wr_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                enter_wr, enter_fot, pix_ok;
    logic                wr_req, wr_is_pix, do_write, do_drop;
    logic [DATA_W-1:0]   wr_req_data;
`ifdef FRAME_HEADER_EN
    logic                frame_start, hdr_pend, skid_vld, skid_load;
    logic [DATA_W-1:0]   skid_data;
`endif

    // Two-FF synchronisers, then one more stage so smp, data and strobes stay aligned:
    // pix_clk sampled high on edge 1 gives smp after edge 3 and wr_en after edge 4.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pclk_s <= '0; fv_s <= '0; lv_s <= '0;
            pd_s1  <= '0; pd_s2 <= '0; pd_smp <= '0;
            pclk_d <= 1'b0; smp <= 1'b0; fv <= 1'b0; lv <= 1'b0;
        end else begin
            pclk_s <= {pclk_s[0], pix_clk};
            fv_s   <= {fv_s[0], frame_vaild};
            lv_s   <= {lv_s[0], line_vaild};
            pd_s1  <= pix_data;
            pd_s2  <= pd_s1;
            pclk_d <= pclk_s[1];
            smp    <= pclk_s[1] & ~pclk_d;
            pd_smp <= pd_s2;
            fv     <= fv_s[1];
            lv     <= lv_s[1];
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_FOT;
        else            state_q <= state_d;
    end

    // Next state; a line end wins over a frame end when both strobes drop together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FOT:  if (fv && lv) state_d = ST_WR;  else if (fv)  state_d = ST_ROT;
            ST_ROT:  if (lv)       state_d = ST_WR;  else if (!fv) state_d = ST_FOT;
            ST_WR:   if (!lv)      state_d = ST_ROT; else if (!fv) state_d = ST_FOT;
            default: state_d = ST_FOT;
        endcase
    end

    // State decodes and write arbitration (header, then skid, then live pixel).
    always_comb begin
        enter_wr    = (state_q != ST_WR) && (state_d == ST_WR);
        enter_fot   = (state_q != ST_FOT) && (state_d == ST_FOT);
        pix_ok      = smp && (state_q == ST_WR) && line_keep;
        wr_req      = pix_ok;
        wr_req_data = pd_smp;
        wr_is_pix   = pix_ok;
`ifdef FRAME_HEADER_EN
        frame_start = (state_q == ST_FOT) && (state_d != ST_FOT);
        skid_load   = 1'b0;
        if (hdr_pend) begin
            wr_req      = 1'b1;
            wr_req_data = DATA_W'(frame_cnt);
            wr_is_pix   = 1'b0;
            skid_load   = pix_ok;
        end else if (skid_vld) begin
            wr_req      = 1'b1;
            wr_req_data = skid_data;
            wr_is_pix   = 1'b1;
        end
`endif
        do_write = wr_req && !fifo_if.fifo_full;
        do_drop  = wr_req && fifo_if.fifo_full;
    end

`ifdef FRAME_HEADER_EN
    // Header slot follows the frame-start transition; a colliding pixel waits one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hdr_pend <= 1'b0; skid_vld <= 1'b0; skid_data <= '0;
        end else begin
            hdr_pend <= frame_start;
            skid_vld <= skid_load;
            if (skid_load) skid_data <= pd_smp;
        end
    end
`endif

    // FIFO write port and sticky overflow flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_en_q <= 1'b0; wr_data_q <= '0; overflow <= 1'b0;
        end else begin
            wr_en_q <= do_write;
            if (do_write) wr_data_q <= wr_req_data;
            if (do_drop)  overflow  <= 1'b1;
        end
    end

    // Pixel/line counters (saturating) and line decimation phase.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_cnt <= '0; line_cnt <= '0; skip_cnt <= '0; line_keep <= 1'b0;
        end else begin
            if (enter_fot || enter_wr)
                pix_cnt <= '0;
            else if (do_write && wr_is_pix && pix_cnt != '1)
                pix_cnt <= pix_cnt + CNT_W'(1);
            if (enter_fot) begin
                line_cnt <= '0;
                skip_cnt <= '0;
            end else if (enter_wr) begin
                if (line_cnt != '1) line_cnt <= line_cnt + CNT_W'(1);
                line_keep <= (skip_cnt == '0);
                skip_cnt  <= (skip_cnt == SKIP_W'(LINE_SKIP)) ? '0 : skip_cnt + SKIP_W'(1);
            end
        end
    end

    // Frame counter: only frames that wrote at least one word are counted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt <= '0; frame_wrote <= 1'b0;
        end else if (enter_fot) begin
            if (frame_wrote || do_write) frame_cnt <= frame_cnt + 8'd1;
            frame_wrote <= 1'b0;
        end else if (do_write) begin
            frame_wrote <= 1'b1;
        end
    end

    // Package counter spans frames; package_ready lines up with the closing wr_en.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkg_cnt <= '0; package_ready <= 1'b0;
        end else begin
            package_ready <= 1'b0;
            if (do_write) begin
                if (pkg_cnt == PKG_W'(PKG_SIZE - 1)) begin
                    pkg_cnt       <= '0;
                    package_ready <= 1'b1;
                end else begin
                    pkg_cnt <= pkg_cnt + PKG_W'(1);
                end
            end
        end
    end

    // Interrupt stretcher; every package_ready reloads the full length.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)          intr_cnt <= '0;
        else if (package_ready)  intr_cnt <= INTR_W'(INTR_LEN);
        else if (intr_cnt != '0) intr_cnt <= intr_cnt - INTR_W'(1);
    end

    assign intr_out        = (intr_cnt != '0);
    assign state           = state_q;
    assign fifo_if.wr_en   = wr_en_q;
    assign fifo_if.wr_data = wr_data_q;
endmodule

// File: tb/tb_daq_frame_ctrl.sv
// tb_daq_frame_ctrl: three capture front-ends fed from one sensor stimulus:
// dut a (LINE_SKIP=0, PKG_SIZE=300, INTR_LEN=4), dut b (LINE_SKIP=2),
// dut c (PKG_SIZE=2, INTR_LEN=12) for back-to-back interrupt retriggering.
module tb_daq_frame_ctrl;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int ND = 3;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic [DW-1:0]        pix_data = '0;
    logic                 pix_clk = 1'b0;
    logic                 frame_vaild = 1'b0;
    logic                 line_vaild = 1'b0;
    logic                 fifo_full = 1'b0;

    logic [ND-1:0]           wr_en_v, pr_v, intr_v, ovf_v;
    logic [ND-1:0][DW-1:0]   wr_data_v;
    logic [ND-1:0][2:0]      state_v;
    logic [ND-1:0][CW-1:0]   pix_cnt_v, line_cnt_v;
    logic [ND-1:0][7:0]      frame_v;

    // clock / reset
    always #10 sys_clk = ~sys_clk;

    daq_frame_ctrl_if #(.DATA_W(DW)) bus_a ();
    daq_frame_ctrl_if #(.DATA_W(DW)) bus_b ();
    daq_frame_ctrl_if #(.DATA_W(DW)) bus_c ();
    assign bus_a.fifo_full = fifo_full;
    assign bus_b.fifo_full = fifo_full;
    assign bus_c.fifo_full = fifo_full;
    assign wr_en_v   = {bus_c.wr_en, bus_b.wr_en, bus_a.wr_en};
    assign wr_data_v = {bus_c.wr_data, bus_b.wr_data, bus_a.wr_data};

    daq_frame_ctrl #(.DATA_W(DW), .PKG_SIZE(300), .LINE_SKIP(0), .INTR_LEN(4), .CNT_W(CW)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data), .pix_clk(pix_clk),
        .frame_vaild(frame_vaild), .line_vaild(line_vaild), .fifo_if(bus_a.master),
        .state(state_v[0]), .pix_cnt(pix_cnt_v[0]), .line_cnt(line_cnt_v[0]), .frame_cnt(frame_v[0]),
        .package_ready(pr_v[0]), .intr_out(intr_v[0]), .overflow(ovf_v[0]));
    daq_frame_ctrl #(.DATA_W(DW), .PKG_SIZE(300), .LINE_SKIP(2), .INTR_LEN(4), .CNT_W(CW)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data), .pix_clk(pix_clk),
        .frame_vaild(frame_vaild), .line_vaild(line_vaild), .fifo_if(bus_b.master),
        .state(state_v[1]), .pix_cnt(pix_cnt_v[1]), .line_cnt(line_cnt_v[1]), .frame_cnt(frame_v[1]),
        .package_ready(pr_v[1]), .intr_out(intr_v[1]), .overflow(ovf_v[1]));
    daq_frame_ctrl #(.DATA_W(DW), .PKG_SIZE(2), .LINE_SKIP(0), .INTR_LEN(12), .CNT_W(CW)) u_dut_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data), .pix_clk(pix_clk),
        .frame_vaild(frame_vaild), .line_vaild(line_vaild), .fifo_if(bus_c.master),
        .state(state_v[2]), .pix_cnt(pix_cnt_v[2]), .line_cnt(line_cnt_v[2]), .frame_cnt(frame_v[2]),
        .package_ready(pr_v[2]), .intr_out(intr_v[2]), .overflow(ovf_v[2]));

    // scoreboard
    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
    int wr_cnt[ND], pr_cnt[ND], intr_hi[ND], intr_rise[ND];
    logic [ND-1:0] intr_prev = '0;
    int pr_in_rst = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int d, input logic [DW-1:0] got);
        logic [DW-1:0] e;
        int n;
        n = (d == 0) ? exp_q0.size() : (d == 1) ? exp_q1.size() : exp_q2.size();
        if (n == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra dut%0d: got word %0h expected no write", d, got);
        end else begin
            if (d == 0)      e = exp_q0.pop_front();
            else if (d == 1) e = exp_q1.pop_front();
            else             e = exp_q2.pop_front();
            check($sformatf("sb_word dut%0d", d), int'(got), int'(e));
        end
    endtask

    // monitor: outputs sampled on the falling edge
    always @(negedge sys_clk) begin
        if (!sys_rst_n && pr_v != '0) pr_in_rst++;
        for (int d = 0; d < ND; d++) begin
            if (wr_en_v[d]) begin
                wr_cnt[d]++;
                sb_pop(d, wr_data_v[d]);
            end
            if (pr_v[d]) pr_cnt[d]++;
            if (intr_v[d]) intr_hi[d]++;
            if (intr_v[d] && !intr_prev[d]) intr_rise[d]++;
        end
        intr_prev = intr_v;
    end

    // driver tasks
    logic [DW-1:0] pix_val = 8'h10;
    int pix_end_a, lc_a, lc_b;

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0; frame_vaild = 1'b0; line_vaild = 1'b0; pix_clk = 1'b0; fifo_full = 1'b0;
        cyc(3);
        sys_rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic push_exp(input bit full, input int line_idx);
        if (!full) begin
            exp_q0.push_back(pix_val);
            exp_q2.push_back(pix_val);
            if (line_idx % 3 == 0) exp_q1.push_back(pix_val);
        end
    endtask

    task automatic pixel(input bit full, input int lo, input int hi, input int line_idx);
        pix_data = pix_val; fifo_full = full; pix_clk = 1'b0;
        push_exp(full, line_idx);
        cyc(lo);
        pix_clk = 1'b1;
        cyc(hi);
        pix_val++;
    endtask

    task automatic send_line(input int n_pix, input int f_from, input int f_n, input int line_idx);
        line_vaild = 1'b1;
        cyc(3);
        for (int p = 0; p < n_pix; p++)
            pixel((p >= f_from) && (p < f_from + f_n), 4, 6, line_idx);
        cyc(2);
        pix_end_a = int'(pix_cnt_v[0]);
        line_vaild = 1'b0; fifo_full = 1'b0;
        cyc(6);
    endtask

    task automatic send_frame(input int n_lines, input int n_pix, input int f_from, input int f_n);
        frame_vaild = 1'b1;
        cyc(4);
        for (int l = 0; l < n_lines; l++) send_line(n_pix, f_from, f_n, l);
        lc_a = int'(line_cnt_v[0]);
        lc_b = int'(line_cnt_v[1]);
        frame_vaild = 1'b0;
        cyc(8);
    endtask

    typedef struct {
        int n_lines, n_pix, f_from, f_n;
        int exp_wr_a, exp_wr_b, exp_pr_a, exp_pr_b, exp_intr_a;
        int exp_lines, exp_pix_a, exp_frame, exp_ovf;
    } vec_t;
    vec_t vec[4];

    initial begin
        int wa, wb, pa, pb, ia, pc, wc, hc, rc, lat;
        bit seen;
        // words accumulate across frames: a packages at 300/600/900/1200, b at 300/600
        vec[0] = '{4, 100, -1, 0, 400, 200, 1, 0, 4, 4, 100, 1, 0};
        vec[1] = '{7, 100, -1, 0, 700, 300, 2, 1, 8, 7, 100, 2, 0};
        vec[2] = '{1, 100, 40, 5,  95,  95, 0, 0, 0, 1,  95, 3, 1};
        vec[3] = '{1,   5, -1, 0,   5,   5, 1, 1, 4, 1,   5, 4, 1};

        do_reset();
        check("rst state", int'(state_v[0]), 1);
        check("rst wr_en", int'(wr_en_v[0]), 0);
        check("rst pix_cnt", int'(pix_cnt_v[0]), 0);
        check("rst line_cnt", int'(line_cnt_v[0]), 0);
        check("rst frame_cnt", int'(frame_v[0]), 0);
        check("rst intr", int'(intr_v[0]), 0);
        check("rst overflow", int'(ovf_v[0]), 0);

        // latency and interrupt retrigger on dut c: 8 words, 4 cycles apart after the first
        frame_vaild = 1'b1; cyc(4);
        line_vaild = 1'b1; cyc(3);
        wc = wr_cnt[2]; pc = pr_cnt[2]; hc = intr_hi[2]; rc = intr_rise[2];
        pix_data = pix_val; pix_clk = 1'b0; push_exp(1'b0, 0);
        cyc(2);
        pix_clk = 1'b1;
        lat = 0; seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge sys_clk);
            if (wr_en_v[2]) begin lat = k; seen = 1'b1; end
        end
        check("latency cycles", lat, 4);
        pix_val++;
        for (int p = 0; p < 7; p++) pixel(1'b0, 2, 2, 0);
        cyc(20);
        check("retrig writes", wr_cnt[2] - wc, 8);
        check("retrig packages", pr_cnt[2] - pc, 4);
        check("retrig intr rises", intr_rise[2] - rc, 1);
        check("retrig intr high", intr_hi[2] - hc, 36);
        line_vaild = 1'b0; cyc(6);
        frame_vaild = 1'b0; cyc(8);
        do_reset();

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            wa = wr_cnt[0]; wb = wr_cnt[1]; pa = pr_cnt[0]; pb = pr_cnt[1]; ia = intr_hi[0];
            send_frame(vec[v].n_lines, vec[v].n_pix, vec[v].f_from, vec[v].f_n);
            check($sformatf("v%0d writes a", v), wr_cnt[0] - wa, vec[v].exp_wr_a);
            check($sformatf("v%0d writes b", v), wr_cnt[1] - wb, vec[v].exp_wr_b);
            check($sformatf("v%0d pkg a", v), pr_cnt[0] - pa, vec[v].exp_pr_a);
            check($sformatf("v%0d pkg b", v), pr_cnt[1] - pb, vec[v].exp_pr_b);
            check($sformatf("v%0d intr a", v), intr_hi[0] - ia, vec[v].exp_intr_a);
            check($sformatf("v%0d line_cnt a", v), lc_a, vec[v].exp_lines);
            check($sformatf("v%0d line_cnt b", v), lc_b, vec[v].exp_lines);
            check($sformatf("v%0d pix_end a", v), pix_end_a, vec[v].exp_pix_a);
            check($sformatf("v%0d frame a", v), int'(frame_v[0]), vec[v].exp_frame);
            check($sformatf("v%0d frame b", v), int'(frame_v[1]), vec[v].exp_frame);
            check($sformatf("v%0d ovf a", v), int'(ovf_v[0]), vec[v].exp_ovf);
            check($sformatf("v%0d ovf b", v), int'(ovf_v[1]), vec[v].exp_ovf);
            check($sformatf("v%0d state a", v), int'(state_v[0]), 1);
        end

        // reset asserted mid-line while wr_en is high
        frame_vaild = 1'b1; cyc(4);
        line_vaild = 1'b1; cyc(3);
        for (int p = 0; p < 3; p++) pixel(1'b0, 4, 6, 0);
        pix_data = pix_val; pix_clk = 1'b0; push_exp(1'b0, 0);
        cyc(4);
        pix_clk = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge sys_clk);
            seen = wr_en_v[0];
        end
        check("midrst wr_en seen", int'(seen), 1);
        #2 sys_rst_n = 1'b0;
        frame_vaild = 1'b0; line_vaild = 1'b0; pix_clk = 1'b0;
        @(negedge sys_clk);
        check("midrst state", int'(state_v[0]), 1);
        check("midrst wr_en", int'(wr_en_v[0]), 0);
        check("midrst pix_cnt", int'(pix_cnt_v[0]), 0);
        check("midrst line_cnt", int'(line_cnt_v[0]), 0);
        check("midrst frame_cnt", int'(frame_v[0]), 0);
        check("midrst intr", int'(intr_v[0]), 0);
        check("midrst overflow", int'(ovf_v[0]), 0);
        cyc(5);
        check("midrst pkg in reset", pr_in_rst, 0);
        sys_rst_n = 1'b1;
        cyc(4);
        check("sb left over", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end
endmodule
